// File: rtl/multi_cycle_ctrl_if.sv
// Control bundle between multi_cycle_ctrl and the SimpleCPU datapath.
// The controller reads the opcode and zero flag and drives every mux select and write enable.
interface multi_cycle_ctrl_if;
  logic [5:0] opcode;
  logic       zero;
  logic       PCWre;
  logic       IRWre;
  logic       InsMemRW;
  logic       ALUSrcB;
  logic       ALUM2Reg;
  logic       RegWre;
  logic       DataMemRW;
  logic       ExtSel;
  logic       PCSrc;
  logic       RegOut;
  logic [2:0] ALUFlag;
  logic [2:0] state;
  logic       halted;

  modport master (
    input  opcode, zero,
    output PCWre, IRWre, InsMemRW, ALUSrcB, ALUM2Reg, RegWre,
           DataMemRW, ExtSel, PCSrc, RegOut, ALUFlag, state, halted
  );

  modport slave (
    output opcode, zero,
    input  PCWre, IRWre, InsMemRW, ALUSrcB, ALUM2Reg, RegWre,
           DataMemRW, ExtSel, PCSrc, RegOut, ALUFlag, state, halted
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control FSM for SimpleCPU: steps each instruction through IF/ID/EXE/MEM/WB.
// Outputs are a combinational decode of the current state, the latched opcode and the ALU zero flag.
module multi_cycle_ctrl (
  input  logic                  click,
  input  logic                  reset,
  multi_cycle_ctrl_if.master    bus
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b111
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_ORI  = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_OR   = 6'b010010;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;

  function automatic logic [2:0] alu_op(input logic [5:0] op);
    case (op)
      OP_SUB, OP_BEQ: alu_op = ALU_SUB;
      OP_OR, OP_ORI:  alu_op = ALU_OR;
      OP_AND:         alu_op = ALU_AND;
      default:        alu_op = ALU_ADD;
    endcase
  endfunction

  state_t     state_q, state_d;
  logic [5:0] op_q;

  always_ff @(posedge click or negedge reset) begin
    if (!reset) begin
      state_q <= S_IF;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) op_q <= bus.opcode;
    end
  end

  // ID looks at the live opcode; later states only ever see the latched copy.
  logic id_halt, id_legal;
  always_comb begin
    id_halt  = (bus.opcode == OP_HALT);
    case (bus.opcode)
      OP_ADD, OP_ADDI, OP_SUB, OP_ORI, OP_AND, OP_OR,
      OP_SW, OP_LW, OP_BEQ: id_legal = 1'b1;
      default:              id_legal = 1'b0;
    endcase
  end

  logic op_rtype, op_lw, op_sw, op_beq, imm_b, sign_ext;
  assign op_rtype = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_AND) || (op_q == OP_OR);
  assign op_lw    = (op_q == OP_LW);
  assign op_sw    = (op_q == OP_SW);
  assign op_beq   = (op_q == OP_BEQ);
  assign imm_b    = (op_q == OP_ADDI) || (op_q == OP_ORI) || op_lw || op_sw;
  assign sign_ext = (op_q == OP_ADDI) || op_lw || op_sw || op_beq;

  logic       pc_wre, ir_wre, ins_mem_rw, alu_src_b, alu_m2reg;
  logic       reg_wre, data_mem_rw, ext_sel, pc_src, reg_out;
  logic [2:0] alu_flag;

  always_comb begin
    state_d     = state_q;
    pc_wre      = 1'b0;
    ir_wre      = 1'b0;
    ins_mem_rw  = 1'b0;
    alu_src_b   = 1'b0;
    alu_m2reg   = 1'b0;
    reg_wre     = 1'b0;
    data_mem_rw = 1'b0;
    ext_sel     = 1'b0;
    pc_src      = 1'b0;
    reg_out     = 1'b0;
    alu_flag    = ALU_ADD;
    case (state_q)
      S_IF: begin
        ins_mem_rw = 1'b1;
        ir_wre     = 1'b1;
        state_d    = S_ID;
      end
      S_ID: begin
        if (id_halt)       state_d = S_HALT;
        else if (id_legal) state_d = S_EXE;
        else begin
          pc_wre  = 1'b1;
          state_d = S_IF;
        end
      end
      S_EXE: begin
        alu_src_b = imm_b;
        ext_sel   = sign_ext;
        alu_flag  = alu_op(op_q);
        if (op_beq) begin
          pc_wre  = 1'b1;
          pc_src  = bus.zero;
          state_d = S_IF;
        end else if (op_lw || op_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        alu_src_b   = imm_b;
        ext_sel     = sign_ext;
        alu_flag    = alu_op(op_q);
        data_mem_rw = op_sw;
        pc_wre      = op_sw;
        state_d     = op_sw ? S_IF : S_WB;
      end
      S_WB: begin
        alu_src_b = imm_b;
        ext_sel   = sign_ext;
        alu_flag  = alu_op(op_q);
        reg_wre   = 1'b1;
        pc_wre    = 1'b1;
        reg_out   = op_rtype;
        alu_m2reg = op_lw;
        state_d   = S_IF;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  assign bus.PCWre     = pc_wre;
  assign bus.IRWre     = ir_wre;
  assign bus.InsMemRW  = ins_mem_rw;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.ALUM2Reg  = alu_m2reg;
  assign bus.RegWre    = reg_wre;
  assign bus.DataMemRW = data_mem_rw;
  assign bus.ExtSel    = ext_sel;
  assign bus.PCSrc     = pc_src;
  assign bus.RegOut    = reg_out;
  assign bus.ALUFlag   = alu_flag;
  assign bus.state     = state_q;
  assign bus.halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: stimulus pushes the hand-derived control word for
// each cycle; a monitor on the falling edge pops and compares it with the DUT outputs.
module tb_multi_cycle_ctrl;

  logic click = 1'b0;
  logic reset = 1'b0;

  multi_cycle_ctrl_if bus ();

  multi_cycle_ctrl dut (
    .click (click),
    .reset (reset),
    .bus   (bus)
  );

  always #5 click = ~click;

  // Control word: {state[2:0], halted, PCWre, IRWre, InsMemRW, ALUSrcB, ALUM2Reg,
  //                RegWre, DataMemRW, ExtSel, PCSrc, RegOut, ALUFlag[2:0]}
  localparam logic [16:0] ST_IF   = 17'h00000;
  localparam logic [16:0] ST_ID   = 17'h04000;
  localparam logic [16:0] ST_EXE  = 17'h08000;
  localparam logic [16:0] ST_MEM  = 17'h0C000;
  localparam logic [16:0] ST_WB   = 17'h10000;
  localparam logic [16:0] ST_HALT = 17'h1C000;
  localparam logic [16:0] B_HLT   = 17'h02000;
  localparam logic [16:0] B_PCW   = 17'h01000;
  localparam logic [16:0] B_IRW   = 17'h00800;
  localparam logic [16:0] B_IMR   = 17'h00400;
  localparam logic [16:0] B_SRCB  = 17'h00200;
  localparam logic [16:0] B_M2R   = 17'h00100;
  localparam logic [16:0] B_REGW  = 17'h00080;
  localparam logic [16:0] B_DMW   = 17'h00040;
  localparam logic [16:0] B_EXT   = 17'h00020;
  localparam logic [16:0] B_PCSRC = 17'h00010;
  localparam logic [16:0] B_ROUT  = 17'h00008;
  localparam logic [16:0] A_SUB   = 17'h00001;
  localparam logic [16:0] A_OR    = 17'h00003;
  localparam logic [16:0] A_AND   = 17'h00004;
  localparam logic [16:0] V_IF    = ST_IF | B_IRW | B_IMR;

  // Driven outside ID to show a stray opcode has no effect.
  localparam logic [5:0] X_OP = 6'b111111;

  logic [16:0] exp_q[$];
  string       name_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always @(negedge click) begin
    logic [16:0] act, exp;
    string       nm;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {bus.state, bus.halted, bus.PCWre, bus.IRWre, bus.InsMemRW, bus.ALUSrcB,
             bus.ALUM2Reg, bus.RegWre, bus.DataMemRW, bus.ExtSel, bus.PCSrc,
             bus.RegOut, bus.ALUFlag};
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s: got %05h expected %05h", nm, act, exp);
      end
      n_tests++;
      if (bus.RegWre && bus.DataMemRW) begin
        n_fail++;
        $display("FAIL %s/wr_excl: got RegWre=1 DataMemRW=1 expected not both", nm);
      end
    end
  end

  task automatic step(input logic [5:0] op, input logic z, input logic [16:0] v, input string nm);
    bus.opcode = op;
    bus.zero   = z;
    exp_q.push_back(v);
    name_q.push_back(nm);
    @(posedge click);
    #1;
  endtask

  // IF, ID, then up to three further states with their expected control words.
  task automatic do_instr(input logic [5:0] op, input logic z, input int n,
                          input logic [16:0] e_id, input logic [16:0] e2,
                          input logic [16:0] e3, input logic [16:0] e4, input string nm);
    step(X_OP, z, V_IF, {nm, "/IF"});
    step(op, z, e_id, {nm, "/ID"});
    if (n > 0) step(X_OP, z, e2, {nm, "/S3"});
    if (n > 1) step(X_OP, z, e3, {nm, "/S4"});
    if (n > 2) step(X_OP, z, e4, {nm, "/S5"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.opcode = X_OP;
    bus.zero   = 1'b0;
    @(posedge click);
    #1;
    step(X_OP, 1'b1, V_IF, "reset_hold");
    reset = 1'b1;

    do_instr(6'b000001, 1'b1, 2, ST_ID, ST_EXE | B_SRCB | B_EXT,
             ST_WB | B_SRCB | B_EXT | B_REGW | B_PCW, 17'h0, "addi");
    do_instr(6'b000000, 1'b1, 2, ST_ID, ST_EXE,
             ST_WB | B_REGW | B_PCW | B_ROUT, 17'h0, "add");
    do_instr(6'b000010, 1'b1, 2, ST_ID, ST_EXE | A_SUB,
             ST_WB | B_REGW | B_PCW | B_ROUT | A_SUB, 17'h0, "sub");
    do_instr(6'b010000, 1'b1, 2, ST_ID, ST_EXE | B_SRCB | A_OR,
             ST_WB | B_SRCB | B_REGW | B_PCW | A_OR, 17'h0, "ori");
    do_instr(6'b010001, 1'b1, 2, ST_ID, ST_EXE | A_AND,
             ST_WB | B_REGW | B_PCW | B_ROUT | A_AND, 17'h0, "and");
    do_instr(6'b010010, 1'b1, 2, ST_ID, ST_EXE | A_OR,
             ST_WB | B_REGW | B_PCW | B_ROUT | A_OR, 17'h0, "or");

    do_instr(6'b100111, 1'b1, 3, ST_ID, ST_EXE | B_SRCB | B_EXT, ST_MEM | B_SRCB | B_EXT,
             ST_WB | B_SRCB | B_EXT | B_REGW | B_PCW | B_M2R, "lw");
    do_instr(6'b100110, 1'b1, 2, ST_ID, ST_EXE | B_SRCB | B_EXT,
             ST_MEM | B_SRCB | B_EXT | B_DMW | B_PCW, 17'h0, "sw");

    do_instr(6'b110000, 1'b1, 1, ST_ID, ST_EXE | B_EXT | A_SUB | B_PCW | B_PCSRC,
             17'h0, 17'h0, "beq_z1");
    do_instr(6'b110000, 1'b0, 1, ST_ID, ST_EXE | B_EXT | A_SUB | B_PCW,
             17'h0, 17'h0, "beq_z0");

    do_instr(6'b101010, 1'b1, 0, ST_ID | B_PCW, 17'h0, 17'h0, 17'h0, "nop");

    // add interrupted by reset in the middle of its WB cycle
    do_instr(6'b000000, 1'b1, 1, ST_ID, ST_EXE, 17'h0, 17'h0, "add_rst");
    bus.opcode = X_OP;
    exp_q.push_back(ST_WB | B_REGW | B_PCW | B_ROUT);
    name_q.push_back("add_rst/WB");
    @(negedge click);
    #1;
    reset = 1'b0;
    @(posedge click);
    #1;
    step(X_OP, 1'b1, V_IF, "rst_midwb");
    reset = 1'b1;
    do_instr(6'b000000, 1'b1, 2, ST_ID, ST_EXE,
             ST_WB | B_REGW | B_PCW | B_ROUT, 17'h0, "add_after_rst");

    do_instr(6'b111111, 1'b1, 0, ST_ID, 17'h0, 17'h0, 17'h0, "halt");
    for (int i = 0; i < 22; i++) begin
      step(6'b000000, 1'b1, ST_HALT | B_HLT, "halt_hold");
    end
    reset = 1'b0;
    step(X_OP, 1'b1, V_IF, "rst_from_halt");
    reset = 1'b1;
    do_instr(6'b000001, 1'b1, 2, ST_ID, ST_EXE | B_SRCB | B_EXT,
             ST_WB | B_SRCB | B_EXT | B_REGW | B_PCW, 17'h0, "addi_after_halt");

    @(negedge click);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
